// File: rtl/lines_stats_controller_pkg.sv
// Shared types and constants for the lines statistics controller.
// Optional build macro LINES_LEADING_ZERO_BLANK_EN is consumed by lines_stats_controller.sv.
package lines_stats_controller_pkg;
  localparam int LINES_MAX_COUNT = 999;
  localparam int LINES_DIGITS    = 3;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef logic [7:0] char_t;

  typedef enum logic [1:0] {IDLE, CONV_LC, CONV_LS, COMMIT} lines_state_t;
endpackage

// File: rtl/lines_stats_controller_bcd_engine.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// load captures a new operand; load+start together also performs the first iteration.
module bcd_shift_engine
  import lines_stats_controller_pkg::*;
#(
  parameter int COUNT_W = 10,
  parameter int DIGITS  = LINES_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  start_i,
  input  logic [COUNT_W-1:0]    bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o
);
  localparam int CNT_W = $clog2(COUNT_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_W);

  logic [COUNT_W-1:0]  bin_q, bin_d, bin_src;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_src, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_src;

  always_comb begin
    bin_src = load_i ? bin_i : bin_q;
    bcd_src = load_i ? '0 : bcd_q;
    cnt_src = load_i ? '0 : cnt_q;
    bcd_adj = bcd_src;
    for (int d = 0; d < DIGITS; d++)
      if (bcd_src[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_src[4*d +: 4] + 4'd3;
    bin_d = bin_src;
    bcd_d = bcd_src;
    cnt_d = cnt_src;
    if (start_i && cnt_src != LAST) begin
      {bcd_d, bin_d} = {bcd_adj, bin_src} << 1;
      cnt_d          = cnt_src + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = (cnt_q == LAST);
endmodule

// File: rtl/lines_stats_controller.sv
// Lines cleared/sent counters with once-per-frame ASCII conversion on a shared BCD engine.
// Define LINES_LEADING_ZERO_BLANK_EN to blank leading zero digits with spaces.
module lines_stats_controller
  import lines_stats_controller_pkg::*;
#(
  parameter int COUNT_W   = 10,
  parameter int MAX_COUNT = LINES_MAX_COUNT,
  parameter int DIGITS    = LINES_DIGITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     frame_start,
  input  logic                     lc_add_valid,
  input  logic [2:0]               lc_add,
  input  logic                     ls_add_valid,
  input  logic [2:0]               ls_add,
  output logic [COUNT_W-1:0]       lines_cleared,
  output logic [COUNT_W-1:0]       lines_sent,
  output logic [DIGITS-1:0][7:0]   lc_chars,
  output logic [DIGITS-1:0][7:0]   ls_chars,
  output logic                     chars_update,
  output logic                     busy
);
  localparam logic [COUNT_W:0]   SUM_MAX = (COUNT_W+1)'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(MAX_COUNT);

  lines_state_t              state_q;
  logic [COUNT_W-1:0]        lc_q, ls_q, ls_snap_q;
  logic [4*DIGITS-1:0]       lc_bcd_q;
  logic [DIGITS-1:0][7:0]    lc_chars_q, ls_chars_q;
  logic                      upd_q, busy_q, pending_q;
  logic                      eng_load, eng_start, eng_done;
  logic [COUNT_W-1:0]        eng_bin;
  logic [4*DIGITS-1:0]       eng_bcd;

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] c,
                                                 input logic [2:0] a);
    logic [COUNT_W:0] s;
    s = {1'b0, c} + {{(COUNT_W-2){1'b0}}, a};
    return (s > SUM_MAX) ? CNT_MAX : s[COUNT_W-1:0];
  endfunction

  // Char index 0 is the most significant digit.
  function automatic logic [DIGITS-1:0][7:0] to_chars(input logic [4*DIGITS-1:0] bcd);
    logic [DIGITS-1:0][7:0] res;
    logic [3:0]             nib;
`ifdef LINES_LEADING_ZERO_BLANK_EN
    logic                   lead;
    lead = 1'b1;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      nib    = bcd[4*(DIGITS-1-i) +: 4];
      res[i] = ASCII_ZERO + {4'd0, nib};
`ifdef LINES_LEADING_ZERO_BLANK_EN
      if (lead && nib == 4'd0 && i != DIGITS-1) res[i] = ASCII_SPACE;
      else                                      lead   = 1'b0;
`endif
    end
    return res;
  endfunction

  // lc is loaded straight from the live counter at the snapshot edge; ls from its shadow.
  assign eng_load  = ((state_q == IDLE) && (frame_start || pending_q)) ||
                     ((state_q == CONV_LC) && eng_done);
  assign eng_start = (state_q == CONV_LC) || (state_q == CONV_LS);
  assign eng_bin   = (state_q == IDLE) ? lc_q : ls_snap_q;

  bcd_shift_engine #(.COUNT_W(COUNT_W), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .load_i  (eng_load),
    .start_i (eng_start),
    .bin_i   (eng_bin),
    .bcd_o   (eng_bcd),
    .done_o  (eng_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lc_q       <= '0;
      ls_q       <= '0;
      ls_snap_q  <= '0;
      lc_bcd_q   <= '0;
      lc_chars_q <= {DIGITS{ASCII_ZERO}};
      ls_chars_q <= {DIGITS{ASCII_ZERO}};
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      lc_q       <= '0;
      ls_q       <= '0;
      lc_chars_q <= to_chars('0);
      ls_chars_q <= to_chars('0);
      upd_q      <= 1'b1;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (lc_add_valid) lc_q <= sat_add(lc_q, lc_add);
      if (ls_add_valid) ls_q <= sat_add(ls_q, ls_add);
      if (frame_start && state_q != IDLE) pending_q <= 1'b1;
      unique case (state_q)
        IDLE: if (frame_start || pending_q) begin
          ls_snap_q <= ls_q;
          pending_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= CONV_LC;
        end
        CONV_LC: if (eng_done) begin
          lc_bcd_q <= eng_bcd;
          state_q  <= CONV_LS;
        end
        CONV_LS: if (eng_done) state_q <= COMMIT;
        COMMIT: begin
          lc_chars_q <= to_chars(lc_bcd_q);
          ls_chars_q <= to_chars(eng_bcd);
          upd_q      <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lines_cleared = lc_q;
  assign lines_sent    = ls_q;
  assign lc_chars      = lc_chars_q;
  assign ls_chars      = ls_chars_q;
  assign chars_update  = upd_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_lines_stats_controller.sv
// Self-checking bench for lines_stats_controller: random adds against an arithmetic model,
// conversion latency, saturation, pending, clear and reset scenarios.
module tb_lines_stats_controller;
  logic             clk = 1'b0;
  logic             rst = 1'b0, clear = 1'b0, frame_start = 1'b0;
  logic             lc_add_valid = 1'b0, ls_add_valid = 1'b0;
  logic [2:0]       lc_add = '0, ls_add = '0;
  logic [9:0]       lines_cleared, lines_sent;
  logic [2:0][7:0]  lc_chars, ls_chars;
  logic             chars_update, busy;

  int checks = 0, failures = 0;
  int m_lc = 0, m_ls = 0;

  lines_stats_controller dut (
    .clk(clk), .rst(rst), .clear(clear), .frame_start(frame_start),
    .lc_add_valid(lc_add_valid), .lc_add(lc_add),
    .ls_add_valid(ls_add_valid), .ls_add(ls_add),
    .lines_cleared(lines_cleared), .lines_sent(lines_sent),
    .lc_chars(lc_chars), .ls_chars(ls_chars),
    .chars_update(chars_update), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int min999(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic logic [2:0][7:0] exp_chars(input int v);
    logic [2:0][7:0] r;
    r[0] = 8'h30 + 8'(v / 100);
    r[1] = 8'h30 + 8'((v / 10) % 10);
    r[2] = 8'h30 + 8'(v % 10);
`ifdef LINES_LEADING_ZERO_BLANK_EN
    if (v < 100) r[0] = 8'h20;
    if (v < 10)  r[1] = 8'h20;
`endif
    return r;
  endfunction

  // Apply this cycle's inputs to the model, clock once, then drop all pulses.
  task automatic tick();
    if (rst || clear) begin
      m_lc = 0;
      m_ls = 0;
    end else begin
      if (lc_add_valid) m_lc = min999(m_lc + int'(lc_add));
      if (ls_add_valid) m_ls = min999(m_ls + int'(ls_add));
    end
    @(posedge clk); #1;
    rst = 1'b0; clear = 1'b0; frame_start = 1'b0;
    lc_add_valid = 1'b0; ls_add_valid = 1'b0;
  endtask

  task automatic rand_adds();
    lc_add_valid = 1'($urandom_range(0, 1));
    lc_add       = 3'($urandom_range(0, 4));
    ls_add_valid = 1'($urandom_range(0, 1));
    ls_add       = 3'($urandom_range(0, 4));
  endtask

  // Pulses frame_start and returns edges until chars_update (bounded at 40).
  task automatic run_frame(input bit with_adds, output int lat, output int s_lc, output int s_ls);
    s_lc = m_lc;
    s_ls = m_ls;
    frame_start = 1'b1;
    tick();
    lat = 0;
    while (!chars_update && lat < 40) begin
      if (with_adds) rand_adds();
      tick();
      lat++;
    end
  endtask

  task automatic set_counts(input int lc, input int ls);
    clear = 1'b1;
    tick();
    while (m_lc < lc || m_ls < ls) begin
      lc_add_valid = (m_lc < lc);
      lc_add       = 3'((lc - m_lc > 4) ? 4 : lc - m_lc);
      ls_add_valid = (m_ls < ls);
      ls_add       = 3'((ls - m_ls > 4) ? 4 : ls - m_ls);
      tick();
    end
  endtask

  task automatic test_reset();
    int lat, sl, ss;
    rst = 1'b1;
    tick();
    checks++;
    if (lines_cleared !== 10'd0 || lines_sent !== 10'd0 || chars_update !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got lc=%0d ls=%0d upd=%b busy=%b exp 0 0 0 0",
               lines_cleared, lines_sent, chars_update, busy);
    end
    checks++;
    if (lc_chars !== {3{8'h30}} || ls_chars !== {3{8'h30}}) begin
      failures++;
      $display("FAIL reset_chars got %h/%h exp 303030/303030", lc_chars, ls_chars);
    end
    run_frame(1'b0, lat, sl, ss);
    checks++;
    if (lat != 22 || lc_chars !== exp_chars(0) || ls_chars !== exp_chars(0) || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_frame got lat=%0d %h/%h busy=%b exp lat=22 %h/%h busy=0",
               lat, lc_chars, ls_chars, busy, exp_chars(0), exp_chars(0));
    end
  endtask

  task automatic test_basic_adds();
    int lat, sl, ss;
    clear = 1'b1;
    tick();
    lc_add_valid = 1'b1; lc_add = 3'd4; ls_add_valid = 1'b1; ls_add = 3'd2; tick();
    lc_add_valid = 1'b1; lc_add = 3'd4; ls_add_valid = 1'b1; ls_add = 3'd2; tick();
    lc_add_valid = 1'b1; lc_add = 3'd3; tick();
    checks++;
    if (lines_cleared !== 10'd11 || lines_sent !== 10'd4) begin
      failures++;
      $display("FAIL basic_counts got %0d/%0d exp 11/4", lines_cleared, lines_sent);
    end
    run_frame(1'b0, lat, sl, ss);
    checks++;
    if (lat != 22 || lc_chars !== exp_chars(11) || ls_chars !== exp_chars(4)) begin
      failures++;
      $display("FAIL basic_chars got lat=%0d %h/%h exp lat=22 %h/%h",
               lat, lc_chars, ls_chars, exp_chars(11), exp_chars(4));
    end
  endtask

  task automatic test_saturation();
    int lat, sl, ss;
    set_counts(997, 998);
    lc_add_valid = 1'b1; lc_add = 3'd4; ls_add_valid = 1'b1; ls_add = 3'd4; tick();
    checks++;
    if (lines_cleared !== 10'd999 || lines_sent !== 10'd999) begin
      failures++;
      $display("FAIL sat_add got %0d/%0d exp 999/999", lines_cleared, lines_sent);
    end
    run_frame(1'b0, lat, sl, ss);
    checks++;
    if (lc_chars !== exp_chars(999) || ls_chars !== exp_chars(999)) begin
      failures++;
      $display("FAIL sat_chars got %h/%h exp %h", lc_chars, ls_chars, exp_chars(999));
    end
    lc_add_valid = 1'b1; lc_add = 3'd1; tick();
    checks++;
    if (lines_cleared !== 10'd999) begin
      failures++;
      $display("FAIL sat_hold got %0d exp 999", lines_cleared);
    end
    set_counts(5, 5);
    lc_add_valid = 1'b1; lc_add = 3'd0; ls_add_valid = 1'b1; ls_add = 3'd0; tick();
    checks++;
    if (lines_cleared !== 10'd5 || lines_sent !== 10'd5) begin
      failures++;
      $display("FAIL add_zero got %0d/%0d exp 5/5", lines_cleared, lines_sent);
    end
  endtask

  task automatic test_pending();
    int n;
    bit extra;
    set_counts(123, 7);
    frame_start = 1'b1; tick();                 // snapshot edge
    tick();
    lc_add_valid = 1'b1; lc_add = 3'd4; tick();
    frame_start = 1'b1; tick();                 // becomes pending
    frame_start = 1'b1; tick();                 // dropped
    n = 4;
    while (!chars_update && n < 40) begin tick(); n++; end
    checks++;
    if (n != 22 || lc_chars !== exp_chars(123) || ls_chars !== exp_chars(7) || lines_cleared !== 10'd127) begin
      failures++;
      $display("FAIL pend_first got lat=%0d %h/%h lc=%0d exp lat=22 %h/%h lc=127",
               n, lc_chars, ls_chars, lines_cleared, exp_chars(123), exp_chars(7));
    end
    n = 0;
    tick(); n++;
    while (!chars_update && n < 40) begin tick(); n++; end
    checks++;
    if (n != 23 || lc_chars !== exp_chars(127)) begin
      failures++;
      $display("FAIL pend_second got gap=%0d %h exp gap=23 %h", n, lc_chars, exp_chars(127));
    end
    extra = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (chars_update || busy) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL pend_single got extra conversion=1 exp 0");
    end
  endtask

  task automatic test_clear();
    bit extra;
    set_counts(55, 9);
    frame_start = 1'b1; tick();                 // state now CONV_LC
    for (int i = 1; i < 10; i++) begin
      if (i == 3) frame_start = 1'b1;           // leave a pending request behind
      tick();
    end
    clear = 1'b1; tick();
    checks++;
    if (busy !== 1'b0 || chars_update !== 1'b1 || lines_cleared !== 10'd0 || lines_sent !== 10'd0) begin
      failures++;
      $display("FAIL clear_ctrl got busy=%b upd=%b lc=%0d ls=%0d exp 0 1 0 0",
               busy, chars_update, lines_cleared, lines_sent);
    end
    checks++;
    if (lc_chars !== exp_chars(0) || ls_chars !== exp_chars(0)) begin
      failures++;
      $display("FAIL clear_chars got %h/%h exp %h", lc_chars, ls_chars, exp_chars(0));
    end
    extra = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (chars_update || busy) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL clear_drop_pending got conversion=1 exp 0");
    end
  endtask

  task automatic test_rst_mid();
    int lat, sl, ss;
    set_counts(321, 45);
    frame_start = 1'b1; tick();
    for (int i = 0; i < 15; i++) tick();        // inside CONV_LS
    rst = 1'b1; lc_add_valid = 1'b1; lc_add = 3'd3; tick();
    checks++;
    if (lines_cleared !== 10'd0 || lines_sent !== 10'd0 || busy !== 1'b0 || chars_update !== 1'b0 ||
        lc_chars !== {3{8'h30}} || ls_chars !== {3{8'h30}}) begin
      failures++;
      $display("FAIL rst_mid got lc=%0d ls=%0d busy=%b upd=%b %h/%h exp reset values",
               lines_cleared, lines_sent, busy, chars_update, lc_chars, ls_chars);
    end
    lc_add_valid = 1'b1; lc_add = 3'd2; tick();
    run_frame(1'b0, lat, sl, ss);
    checks++;
    if (lat != 22 || lc_chars !== exp_chars(2) || ls_chars !== exp_chars(0)) begin
      failures++;
      $display("FAIL rst_recover got lat=%0d %h/%h exp lat=22 %h/%h",
               lat, lc_chars, ls_chars, exp_chars(2), exp_chars(0));
    end
  endtask

  task automatic test_random();
    int lat, sl, ss, len;
    clear = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(10, 120);
      for (int c = 0; c < len; c++) begin
        rand_adds();
        tick();
        checks++;
        if (lines_cleared !== 10'(m_lc) || lines_sent !== 10'(m_ls)) begin
          failures++;
          $display("FAIL rand_count r=%0d got %0d/%0d exp %0d/%0d",
                   r, lines_cleared, lines_sent, m_lc, m_ls);
        end
      end
      run_frame(1'b1, lat, sl, ss);
      checks++;
      if (lat != 22 || lc_chars !== exp_chars(sl) || ls_chars !== exp_chars(ss)) begin
        failures++;
        $display("FAIL rand_frame r=%0d got lat=%0d %h/%h exp lat=22 %h/%h",
                 r, lat, lc_chars, ls_chars, exp_chars(sl), exp_chars(ss));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_adds();
    test_saturation();
    test_pending();
    test_clear();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
